// File: rtl/pulse_if_pkg.sv
// Constants and state encoding shared by the pulse-train transmitter and the
// pulse-counting detector on the other end of the single-bit `x` line.
package pulse_if_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_GAP   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/gap_counter.sv
// Down-counter that times the low gap between pulses; loading sets it to
// GAP-1 so that the LOW state spans exactly GAP cycles ending at zero.
module gap_counter #(
    parameter int GAP = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic zero
);

    localparam int CW = $clog2(GAP + 1);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= CW'(GAP - 1);
        end else if (en && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - CW'(1);
        end
    end

    assign zero = (cnt_reg == '0);

endmodule

// File: rtl/pulse_train_tx.sv
// Emits `value` one-cycle pulses on x separated by GAP low cycles, then a
// one-cycle z strobe. All outputs come straight from flops.
module pulse_train_tx
    import pulse_if_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int GAP   = DEF_GAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    output logic             x,
    output logic             busy,
    output logic [WIDTH-1:0] remaining,
    output logic             z
);

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] remaining_reg;
    logic             x_reg;
    logic             x_next;
    logic             busy_reg;
    logic             busy_next;
    logic             z_reg;
    logic             z_next;
    logic             gap_load;
    logic             gap_en;
    logic             gap_zero;

    gap_counter #(
        .GAP (GAP)
    ) u_gap (
        .clk   (clk),
        .reset (reset),
        .load  (gap_load),
        .en    (gap_en),
        .zero  (gap_zero)
    );

    assign gap_load = (state_reg == HIGH);
    assign gap_en   = (state_reg == LOW);

    // State and output registers; outputs track the state being entered so
    // they line up with state_reg without any decode after the flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            x_reg     <= 1'b0;
            busy_reg  <= 1'b0;
            z_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            x_reg     <= x_next;
            busy_reg  <= busy_next;
            z_reg     <= z_next;
        end
    end

    // Count is latched on acceptance and only decremented in HIGH, where it
    // is at least 1, so it cannot wrap and reads 0 throughout DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            remaining_reg <= '0;
        end else if ((state_reg == IDLE) && start) begin
            remaining_reg <= value;
        end else if (state_reg == HIGH) begin
            remaining_reg <= remaining_reg - WIDTH'(1);
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = (value == '0) ? DONE : HIGH;
                end
            end
            HIGH: begin
                state_next = (remaining_reg == WIDTH'(1)) ? DONE : LOW;
            end
            LOW: begin
                if (gap_zero) begin
                    state_next = HIGH;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        x_next    = (state_next == HIGH);
        busy_next = (state_next != IDLE);
        z_next    = (state_next == DONE);
    end

    assign x         = x_reg;
    assign busy      = busy_reg;
    assign z         = z_reg;
    assign remaining = remaining_reg;

endmodule

// File: tb/tb_pulse_train_tx.sv
// Directed bench for pulse_train_tx: a table of train lengths plus
// hand-written sequences for reset, exact waveform and ignore rules.
module tb_pulse_train_tx;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] value;
    logic       x;
    logic       busy;
    logic [3:0] remaining;
    logic       z;

    int total;
    int bad;

    typedef struct {
        int v;
        int pulses;
        int busy_n;
    } vec_t;

    vec_t tbl[6];

    pulse_train_tx #(
        .WIDTH (4),
        .GAP   (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .value     (value),
        .x         (x),
        .busy      (busy),
        .remaining (remaining),
        .z         (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled on negedges.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_train(input int v, output int pulses, output int busy_n,
                             output int zs, output int first_x);
        start = 1'b1;
        value = 4'(v);
        step();
        start = 1'b0;
        value = 4'hA;
        pulses = 0;
        busy_n = 0;
        zs = 0;
        first_x = -1;
        for (int c = 1; c <= 60; c++) begin
            if (x) begin
                pulses++;
                if (first_x < 0) first_x = c;
            end
            if (busy) busy_n++;
            if (z) zs++;
            step();
        end
    endtask

    initial begin
        int pulses, busy_n, zs, first_x;
        int exp_x[8];
        int exp_rem[8];
        int exp_z[8];
        total = 0;
        bad = 0;

        tbl[0] = '{v: 3,  pulses: 3,  busy_n: 8};
        tbl[1] = '{v: 0,  pulses: 0,  busy_n: 1};
        tbl[2] = '{v: 15, pulses: 15, busy_n: 44};
        tbl[3] = '{v: 1,  pulses: 1,  busy_n: 2};
        tbl[4] = '{v: 5,  pulses: 5,  busy_n: 14};
        tbl[5] = '{v: 2,  pulses: 2,  busy_n: 5};

        exp_x   = '{1, 0, 0, 1, 0, 0, 1, 0};
        exp_rem = '{3, 2, 2, 2, 1, 1, 1, 0};
        exp_z   = '{0, 0, 0, 0, 0, 0, 0, 1};

        reset = 1'b1;
        start = 1'b0;
        value = 4'd0;
        step();
        step();
        chk("reset_x", int'(x), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_z", int'(z), 0);
        chk("reset_remaining", int'(remaining), 0);
        reset = 1'b0;
        step();

        for (int i = 0; i < 6; i++) begin
            run_train(tbl[i].v, pulses, busy_n, zs, first_x);
            chk($sformatf("v%0d_pulses", tbl[i].v), pulses, tbl[i].pulses);
            chk($sformatf("v%0d_busy_cycles", tbl[i].v), busy_n, tbl[i].busy_n);
            chk($sformatf("v%0d_z_count", tbl[i].v), zs, 1);
            chk($sformatf("v%0d_first_x_cycle", tbl[i].v), first_x,
                (tbl[i].v != 0) ? 1 : -1);
        end

        // Cycle-exact waveform for value=3.
        start = 1'b1;
        value = 4'd3;
        step();
        start = 1'b0;
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("wave3_x_c%0d", c + 1), int'(x), exp_x[c]);
            chk($sformatf("wave3_rem_c%0d", c + 1), int'(remaining), exp_rem[c]);
            chk($sformatf("wave3_z_c%0d", c + 1), int'(z), exp_z[c]);
            chk($sformatf("wave3_busy_c%0d", c + 1), int'(busy), 1);
            step();
        end
        chk("wave3_busy_after", int'(busy), 0);

        // Reset mid-pulse must drop x with no clock edge.
        start = 1'b1;
        value = 4'd5;
        step();
        start = 1'b0;
        chk("midreset_x_before", int'(x), 1);
        reset = 1'b1;
        #1;
        chk("midreset_x_async", int'(x), 0);
        chk("midreset_busy_async", int'(busy), 0);
        step();
        reset = 1'b0;
        zs = 0;
        busy_n = 0;
        for (int c = 0; c < 20; c++) begin
            if (z) zs++;
            if (busy) busy_n++;
            step();
        end
        chk("midreset_z_count", zs, 0);
        chk("midreset_busy_cycles", busy_n, 0);
        chk("midreset_remaining", int'(remaining), 0);

        // start/value changes while busy are ignored.
        start = 1'b1;
        value = 4'd2;
        step();
        value = 4'd9;
        pulses = 0;
        zs = 0;
        for (int c = 1; c <= 20; c++) begin
            if (c == 3) start = 1'b0;
            if (x) pulses++;
            if (z) zs++;
            step();
        end
        chk("ignore_pulses", pulses, 2);
        chk("ignore_z_count", zs, 1);

        // start held high with value=1: 1 (HIGH), 0 (DONE), 0 (IDLE), repeat.
        start = 1'b1;
        value = 4'd1;
        step();
        for (int c = 0; c < 9; c++) begin
            chk($sformatf("held_x_c%0d", c + 1), int'(x), (c % 3 == 0) ? 1 : 0);
            chk($sformatf("held_z_c%0d", c + 1), int'(z), (c % 3 == 1) ? 1 : 0);
            step();
        end
        start = 1'b0;
        for (int c = 0; c < 4; c++) step();
        chk("held_idle_busy", int'(busy), 0);

        // Reset and start together: reset wins.
        reset = 1'b1;
        start = 1'b1;
        value = 4'd4;
        step();
        start = 1'b0;
        reset = 1'b0;
        step();
        chk("reset_start_busy", int'(busy), 0);
        chk("reset_start_x", int'(x), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pulse_train_tx.md
Name: pulse_train_tx

Overview:
- Transmit side of the single-bit pulse interface `x` used by the pulse-counting detector block.
- On a start request, latches an N-bit count and emits exactly that many one-cycle high pulses on `x`, each followed by a fixed low gap.
- Flags completion with a one-cycle `z` strobe.
- Sits upstream of the detector, so the pair forms a closed loop for block-level and board-level test.

Parameters:
- WIDTH, 4, width of the count value and the `remaining` output.
- GAP, 2, number of low cycles inserted after each pulse except the last; legal range 1..15.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request to send; sampled only in IDLE.
- value  input  WIDTH  number of pulses to send; latched when start is accepted.
- x  output  1  serial pulse output, registered.
- busy  output  1  high from the cycle after start is accepted through the DONE cycle.
- remaining  output  WIDTH  pulses still to be sent, registered.
- z  output  1  one-cycle completion strobe, registered.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; x=0, busy=0, z=0, remaining=0; gap counter=0.
  - Takes effect immediately, including mid-train: x drops with no further clock edge.
  - The train is abandoned; z does not fire.
- Clocking: all state changes on the rising edge of clk. All outputs are decoded from registered state, with no combinational path from any input to any output.
- States are IDLE, HIGH, LOW and DONE.
- IDLE:
  - x=0, busy=0, z=0.
  - start=1 at an edge loads remaining<=value.
  - If value!=0, next state is HIGH; if value==0, next state is DONE (no pulses, z still strobes).
- HIGH: lasts exactly 1 cycle.
  - x=1, busy=1.
  - At the closing edge, remaining decrements by 1.
  - If the decremented value is 0, next state is DONE.
  - Otherwise, gap counter loads GAP-1 and next state is LOW.
- LOW: lasts exactly GAP cycles.
  - x=0, busy=1.
  - Gap counter decrements each cycle; on reaching 0, next state is HIGH.
- DONE: lasts exactly 1 cycle.
  - z=1, busy=1, x=0, remaining=0.
  - Next state is IDLE.
  - start is ignored in DONE. Earliest restart is start asserted in the first IDLE cycle.
- Latency:
  - Edge that accepts start to first x=1 cycle: 1 cycle.
  - Total busy cycles for count N>0: N + (N-1)*GAP + 1.
  - For N=0: 1 cycle (DONE only).
- start while busy: ignored. value changes while busy: ignored, because the count was latched at acceptance.
- Maximum count: value = 2^WIDTH-1 sends 15 pulses at WIDTH=4. remaining never wraps because it is decremented only in HIGH, where it is >=1.
- start held continuously: after each DONE, one IDLE cycle occurs, then a new train starts, so back-to-back trains are separated by exactly 1 idle cycle.
- Simultaneous reset and start: reset wins and start is lost.

Decomposition:
- Shared package `pulse_if_pkg`:
  - state enum: IDLE=2'd0, HIGH=2'd1, LOW=2'd2, DONE=2'd3.
  - localparam DEF_WIDTH=4, DEF_GAP=2.
  - The detector side reuses the same constants.
- One natural sub-module, `gap_counter`: a down-counter with load, enable, and a zero flag, sized $clog2(GAP+1). The rest, FSM and remaining counter, stays in the top module.

Test Plan:
- Reset mid-train: assert reset while x=1 → x=0 immediately (before the next edge). After release: busy=0, remaining=0, no z strobe.
- value=3, GAP=2, single start pulse → x over the next cycles is 1,0,0,1,0,0,1,0. z=1 in cycle 8 only; busy high for cycles 1..8; remaining steps 3→2→1→0 at the end of each HIGH cycle.
- value=0, start pulse → x stays 0; z=1 one cycle after acceptance; busy high for exactly 1 cycle.
- value=15, GAP=2 → exactly 15 x pulses, busy for 15+14*2+1=44 cycles, z once.
- Ignore rules:
  - During value=2, pulse start again and change value to 9 mid-train → still exactly 2 pulses; no second train starts.
  - start held high continuously with value=1 → x pattern 1,0(DONE),0(IDLE),1,... with one z per train.
